input_debouncer: RTL and testbench

- Conditions an asynchronous, bouncy board-level input (push button, NMI/reset switch, DIP line) for the clk domain.
- Synchronizes the input, then accepts a new level only after it has been stable for a programmable number of cycles.
- Provides a clean level plus single-cycle rise/fall strobes.
- Sits directly upstream of the sticky edge detector; the edge detector's sig input is driven from level.

---
 rtl/input_debouncer_if.sv | 17 +
 rtl/input_debouncer.sv | 88 ++++++++
 tb/tb_input_debouncer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/input_debouncer_if.sv
// Signal bundle between a raw board input and its debouncer.
// The glitch_count member exists only when DEBOUNCE_GLITCH_COUNT_EN is defined.
interface input_debouncer_if;
  logic       din_async;
  logic       level;
  logic       rise;
  logic       fall;
`ifdef DEBOUNCE_GLITCH_COUNT_EN
  logic [7:0] glitch_count;

  modport master (output din_async, input level, input rise, input fall, input glitch_count);
  modport slave  (input din_async, output level, output rise, output fall, output glitch_count);
`else
  modport master (output din_async, input level, input rise, input fall);
  modport slave  (input din_async, output level, output rise, output fall);
`endif
endinterface

// File: rtl/input_debouncer.sv
// Synchronizes and debounces a bouncy asynchronous input into a clean level with rise/fall strobes.
// Optional rejected-glitch counter enabled by defining DEBOUNCE_GLITCH_COUNT_EN.
module input_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit RESET_LEVEL     = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input_debouncer_if.slave   bus
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   s_in_s;
  logic                   level_r;
  logic [CW-1:0]          count_r;
  logic                   rise_r;
  logic                   fall_r;

  logic                   level_nxt_s;
  logic [CW-1:0]          count_nxt_s;
  logic                   rise_nxt_s;
  logic                   fall_nxt_s;

  assign s_in_s = sync_r[SYNC_STAGES-1];

  // Qualification: a differing s_in must persist for DEBOUNCE_CYCLES evaluations before level flips.
  always_comb begin
    level_nxt_s = level_r;
    count_nxt_s = {CW{1'b0}};
    rise_nxt_s  = 1'b0;
    fall_nxt_s  = 1'b0;
    if (s_in_s != level_r) begin
      if (count_r == CNT_MAX) begin
        level_nxt_s = s_in_s;
        rise_nxt_s  = s_in_s;
        fall_nxt_s  = ~s_in_s;
      end else begin
        count_nxt_s = count_r + CNT_ONE;
      end
    end else begin
      count_nxt_s = {CW{1'b0}};
    end
  end

  // Synchronizer chain and debounce state; strobes are registered alongside level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_r  <= {SYNC_STAGES{RESET_LEVEL}};
      level_r <= RESET_LEVEL;
      count_r <= {CW{1'b0}};
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else begin
      sync_r  <= {sync_r[SYNC_STAGES-2:0], bus.din_async};
      level_r <= level_nxt_s;
      count_r <= count_nxt_s;
      rise_r  <= rise_nxt_s;
      fall_r  <= fall_nxt_s;
    end
  end

  assign bus.level = level_r;
  assign bus.rise  = rise_r;
  assign bus.fall  = fall_r;

`ifdef DEBOUNCE_GLITCH_COUNT_EN
  logic [7:0] glitch_r;

  // A run that returns to level before qualifying counts as one glitch; saturates at 255.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      glitch_r <= 8'd0;
    end else if ((s_in_s == level_r) && (count_r != {CW{1'b0}}) && (glitch_r != 8'hFF)) begin
      glitch_r <= glitch_r + 8'd1;
    end else begin
      glitch_r <= glitch_r;
    end
  end

  assign bus.glitch_count = glitch_r;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Directed table-driven bench for input_debouncer (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// A second instance with RESET_LEVEL=1 is checked during reset.
module tb_input_debouncer;

  typedef struct {
    logic rst_n;
    logic din;
    logic lvl;
    logic rise;
    logic fall;
    int   gl;     // expected glitch_count, -1 = not checked on this row
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vecs[$];

  input_debouncer_if bus0();
  input_debouncer_if bus1();

  input_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_LEVEL(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  input_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_LEVEL(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0d want %0d", name, idx, act, exp);
    end
  endtask

  task automatic add(input int n, input logic r, input logic d, input logic l,
                     input logic ri, input logic fa, input int gl);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.rst_n = r; v.din = d; v.lvl = l; v.rise = ri; v.fall = fa;
      v.gl = (i == n - 1) ? gl : -1;
      vecs.push_back(v);
    end
  endtask

  task automatic drive(input logic r, input logic d);
    rst_n = r;
    bus0.din_async = d;
    bus1.din_async = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus0.din_async = 1'b1;
    bus1.din_async = 1'b1;

    // 1: reset with din=1, then release -> rise at 6th edge after release
    add(3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    add(5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    add(1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, -1);
    add(1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    // fall back to 0
    add(5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    add(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    add(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    // 2: clean rise held 10 cycles, then clean fall
    add(5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    add(1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, -1);
    add(4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    add(5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    add(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    add(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    // 3: 3-cycle glitch is rejected, counted once the input returns
    add(3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    add(3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    add(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    // 4: reset, bounce train of 10 toggles every 2 cycles, then stable 1
    add(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    for (int k = 1; k <= 10; k++) begin
      add(2, 1'b1, k[0], 1'b0, 1'b0, 1'b0, -1);
    end
    add(5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5);
    add(1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, -1);
    add(1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5);
    // 5: reset, then reset again mid-qualification
    add(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    add(3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    add(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    add(5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    add(1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, -1);
    add(1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].din);
      check("level", i, {7'd0, bus0.level}, {7'd0, vecs[i].lvl});
      check("rise",  i, {7'd0, bus0.rise},  {7'd0, vecs[i].rise});
      check("fall",  i, {7'd0, bus0.fall},  {7'd0, vecs[i].fall});
      if (vecs[i].rst_n == 1'b0) begin
        check("rl1_level", i, {7'd0, bus1.level}, 8'd1);
        check("rl1_fall",  i, {7'd0, bus1.fall},  8'd0);
      end
`ifdef DEBOUNCE_GLITCH_COUNT_EN
      if (vecs[i].gl >= 0) begin
        check("glitch_count", i, bus0.glitch_count, 8'(vecs[i].gl));
      end
`endif
    end

    // 6: 300 isolated 2-cycle pulses, level must stay 0, counter saturates
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    for (int p = 0; p < 300; p++) begin
      for (int c = 0; c < 8; c++) begin
        drive(1'b1, (c < 2) ? 1'b1 : 1'b0);
        if (c == 7) begin
          check("sat_level", p, {7'd0, bus0.level}, 8'd0);
          check("sat_rise",  p, {7'd0, bus0.rise},  8'd0);
        end
      end
    end
`ifdef DEBOUNCE_GLITCH_COUNT_EN
    check("glitch_sat", 0, bus0.glitch_count, 8'd255);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
